// File: rtl/bemicro_io_ctrl.sv
// BeMicro pushbutton debouncer with edge pulses and per-LED duty registers.
// Define BEMICRO_IO_LED_PWM_EN for PWM-dimmed LEDs; otherwise each LED is on when its duty is non-zero.
module bemicro_io_ctrl #(
  parameter int unsigned NUM_PB          = 4,
  parameter int unsigned NUM_LED         = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned PWM_BITS        = 8
) (
  input  logic                SYS_CLK,
  input  logic                RESET,
  input  logic [NUM_PB-1:0]   PB,
  output logic [NUM_PB-1:0]   pb_state,
  output logic [NUM_PB-1:0]   pb_press,
  output logic [NUM_PB-1:0]   pb_release,
  input  logic                led_wr,
  input  logic [3:0]          led_sel,
  input  logic [PWM_BITS-1:0] led_duty,
  output logic [NUM_LED-1:0]  USER_LED
);

  localparam int unsigned     CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_PB-1:0]   pb_meta;
  logic [NUM_PB-1:0]   pb_sync;
  logic [CNT_W-1:0]    db_cnt [NUM_PB];
  logic [PWM_BITS-1:0] shadow [NUM_LED];

  // Buttons are active-low; invert at the first flop so everything downstream is 1 = pressed.
  always_ff @(posedge SYS_CLK or posedge RESET) begin
    if (RESET) begin
      pb_meta <= '0;
      pb_sync <= '0;
    end else begin
      pb_meta <= ~PB;
      pb_sync <= pb_meta;
    end
  end

  always_ff @(posedge SYS_CLK or posedge RESET) begin
    if (RESET) begin
      for (int unsigned i = 0; i < NUM_PB; i++) db_cnt[i] <= '0;
      pb_state   <= '0;
      pb_press   <= '0;
      pb_release <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PB; i++) begin
        pb_press[i]   <= 1'b0;
        pb_release[i] <= 1'b0;
        if (pb_sync[i] == pb_state[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          db_cnt[i]     <= '0;
          pb_state[i]   <= pb_sync[i];
          pb_press[i]   <= pb_sync[i];
          pb_release[i] <= ~pb_sync[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Out-of-range selects match no entry, so such writes fall through harmlessly.
  always_ff @(posedge SYS_CLK or posedge RESET) begin
    if (RESET) begin
      for (int unsigned i = 0; i < NUM_LED; i++) shadow[i] <= '0;
    end else if (led_wr) begin
      for (int unsigned i = 0; i < NUM_LED; i++) begin
        if (led_sel == 4'(i)) shadow[i] <= led_duty;
      end
    end
  end

`ifdef BEMICRO_IO_LED_PWM_EN
  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] active [NUM_LED];

  // Duties latch at the last count so a period never mixes old and new values.
  always_ff @(posedge SYS_CLK or posedge RESET) begin
    if (RESET) begin
      pwm_cnt  <= '0;
      USER_LED <= '0;
      for (int unsigned i = 0; i < NUM_LED; i++) active[i] <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (pwm_cnt == PWM_MAX) begin
        for (int unsigned i = 0; i < NUM_LED; i++) active[i] <= shadow[i];
      end
      for (int unsigned i = 0; i < NUM_LED; i++) begin
        USER_LED[i] <= (active[i] == PWM_MAX) || (pwm_cnt < active[i]);
      end
    end
  end
`else
  always_ff @(posedge SYS_CLK or posedge RESET) begin
    if (RESET) begin
      USER_LED <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_LED; i++) USER_LED[i] <= (shadow[i] != '0);
    end
  end
`endif

endmodule

// File: doc/bemicro_io_ctrl.md
BEMICRO_IO_CTRL -- requirements
Module: bemicro_io_ctrl

Interface
REQ-001 Parameter NUM_PB, default 4: pushbutton count, legal range 1..8.
REQ-002 Parameter NUM_LED, default 8: LED count, legal range 1..16.
REQ-003 Parameter DEBOUNCE_CYCLES, default 500000: stable-cycle count, 10 ms at 50 MHz, minimum 2.
REQ-004 Parameter PWM_BITS, default 8: PWM counter and duty width, legal range 2..12.
REQ-005 SYS_CLK  in  1: the single clock, 50 MHz board oscillator.
REQ-006 RESET  in  1: asynchronous, active-high reset.
REQ-007 PB  in  NUM_PB: raw pushbuttons, active-low, asynchronous to SYS_CLK.
REQ-008 pb_state  out  NUM_PB: debounced level per button, 1 = pressed.
REQ-009 pb_press  out  NUM_PB: one-cycle pulse on each debounced press.
REQ-010 pb_release  out  NUM_PB: one-cycle pulse on each debounced release.
REQ-011 led_wr  in  1: duty write strobe, sampled every cycle.
REQ-012 led_sel  in  4: LED index for the write.
REQ-013 led_duty  in  PWM_BITS: duty value for the write.
REQ-014 USER_LED  out  NUM_LED: LED drive, 1 = lit.

Function
REQ-015 Each PB bit SHALL pass through a 2-flop synchroniser, inverted so that 1 = pressed.
REQ-016 Each button SHALL own a debounce counter that increments while the synchronised level differs from pb_state and clears while the two are equal.
REQ-017 When the counter reaches DEBOUNCE_CYCLES-1 while still mismatched, pb_state SHALL toggle on the next edge and the counter SHALL clear.
REQ-018 Any bounce before the counter reaches DEBOUNCE_CYCLES-1 SHALL clear the counter, leaving pb_state unchanged.
REQ-019 Latency from a clean raw edge to the pb_state change SHALL be DEBOUNCE_CYCLES+2 cycles.
REQ-020 pb_press[i] SHALL be high only in the first cycle pb_state[i] is 1; pb_release[i] SHALL be high only in the first cycle pb_state[i] is 0.
REQ-021 A write with led_wr=1 and led_sel<NUM_LED SHALL load led_duty into shadow[led_sel].
REQ-022 A write with led_sel>=NUM_LED SHALL be ignored without side effect.
REQ-023 Buttons SHALL be independent of each other; simultaneous events on several buttons SHALL each produce their own pulses in the same cycle.

Reset
REQ-024 While RESET=1, all outputs and state SHALL clear immediately, independent of SYS_CLK:
- pb_state, pb_press, pb_release = 0
- synchronisers hold "released"
- debounce counters = 0
- shadow and active duties = 0
- PWM counter = 0
- USER_LED = 0
REQ-025 Reset asserted mid-debounce or mid-PWM-period SHALL abandon that operation. After release, a button already held SHALL produce pb_press DEBOUNCE_CYCLES+2 cycles later.

Configuration
REQ-026 Macro BEMICRO_IO_LED_PWM_EN, when defined, SHALL implement the PWM behaviour below.
- A free-running PWM_BITS counter wraps from 2^PWM_BITS-1 to 0.
- When the counter equals its maximum, active[i] loads from shadow[i], so new duties take effect at counter 0.
- A write in that same cycle SHALL take effect one period later.
- USER_LED[i] is registered as (counter < active[i]).
- Duty value all-ones forces the LED constantly lit.
- Duty value 0 holds the LED constantly dark.
REQ-027 When BEMICRO_IO_LED_PWM_EN is undefined, the block SHALL behave as follows.
- No PWM counter or active registers are built.
- USER_LED[i] SHALL be registered as (shadow[i] != 0), changing one cycle after the write.

Verification
REQ-028 Bench parameters: DEBOUNCE_CYCLES=4, PWM_BITS=4.
- Stimulus: PB[0] falls and holds.
- Required: pb_state[0] rises 6 cycles later; pb_press[0] is high for exactly 1 cycle.
REQ-029 Bounce rejection.
- Stimulus: PB[1] low for 3 cycles, high for 1 cycle, then low and held.
- Required: no change during the bounce; pb_state[1] rises 6 cycles after the final fall.
REQ-030 Simultaneous release.
- Stimulus: buttons 0 and 2 released in the same cycle.
- Required: pb_release[0] and pb_release[2] pulse in the same cycle.
REQ-031 PWM duty (macro defined).
- Stimulus: write duty 5 to LED 3, then 15 to LED 4, then 0 to LED 5.
- Required: over each 16-cycle period, USER_LED[3] is high 5 cycles, USER_LED[4] is high 16 cycles, USER_LED[5] is high 0 cycles.
- Required: the new duty is not visible before the next counter wrap.
- Required: a write to led_sel=9 with NUM_LED=8 leaves all LEDs unchanged.
REQ-032 Reset and static mode.
- Stimulus: assert RESET mid-period with LEDs lit.
- Required: USER_LED is 0 within the same cycle.
- Stimulus: macro undefined, write duty 1 to LED 0.
- Required: USER_LED[0] is 1 the cycle after the write.
